// File: rtl/add_resp_checker.sv
// -----------------------------------------------------------------------------
// add_resp_checker
//
// Response-side checker for a clk-registered adder. It watches the same
// (op_a, op_b) stream that feeds the adder and carries a model sum through a
// LATENCY-deep pipeline. That sum is compared with the adder result (res) in
// the cycle where the result is due. The block reports each compare, keeps
// saturating pass and error counters, and holds a snapshot of the first
// failing transaction.
//
// Parameters
//   WIDTH    operand/result width in bits
//   LATENCY  cycles from operand presentation to a valid result (1..8)
//   CNT_W    width of the pass and error counters
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   clear      in   synchronous flush of pipeline, counters and snapshot
//   op_valid   in   operands on op_a/op_b are live this cycle
//   op_a/op_b  in   operands as driven to the adder
//   res        in   adder result
//   chk_valid  out  a compare happens this cycle (combinational)
//   mismatch   out  res differs from exp_sum while chk_valid (combinational)
//   exp_sum    out  expected sum under compare, 0 when idle (combinational)
//   pass_cnt   out  matched compares, saturating
//   err_cnt    out  mismatched compares, saturating
//   fail       out  sticky: any mismatch since rst/clear
//   first_a    out  op_a of the first mismatch
//   first_b    out  op_b of the first mismatch
//   first_got  out  res seen at the first mismatch
// -----------------------------------------------------------------------------
module add_resp_checker #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] res,
  output logic             chk_valid,
  output logic             mismatch,
  output logic [WIDTH-1:0] exp_sum,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [WIDTH-1:0] first_got
);

  if ((LATENCY < 1) || (LATENCY > 8)) begin : g_bad_latency
    $error("add_resp_checker: LATENCY must be in 1..8");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Transaction pipeline: stage 0 captures the operands, stage LATENCY-1 is checked
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]   a_q   [LATENCY];
  logic [WIDTH-1:0]   a_d   [LATENCY];
  logic [WIDTH-1:0]   b_q   [LATENCY];
  logic [WIDTH-1:0]   b_d   [LATENCY];
  logic [WIDTH-1:0]   sum_q [LATENCY];
  logic [WIDTH-1:0]   sum_d [LATENCY];

  // Counters and first-failure snapshot
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] first_a_q, first_a_d;
  logic [WIDTH-1:0] first_b_q, first_b_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;

  // Next-state of the pipeline: shift every cycle, or flush on clear
  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    if (clear) begin
      // Operands presented together with clear are dropped along with the rest
      vld_d = {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        a_d[i]   = {WIDTH{1'b0}};
        b_d[i]   = {WIDTH{1'b0}};
        sum_d[i] = {WIDTH{1'b0}};
      end
    end else begin
      vld_d[0] = op_valid;
      a_d[0]   = op_a;
      b_d[0]   = op_b;
      sum_d[0] = op_a + op_b; // carry-out intentionally dropped
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        a_d[i]   = a_q[i-1];
        b_d[i]   = b_q[i-1];
        sum_d[i] = sum_q[i-1];
      end
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        a_q[i]   <= {WIDTH{1'b0}};
        b_q[i]   <= {WIDTH{1'b0}};
        sum_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
    end
  end

  // Compare against the adder result in the cycle the last stage is valid
  always_comb begin
    chk_valid = vld_q[LATENCY-1];
    exp_sum   = {WIDTH{1'b0}};
    mismatch  = 1'b0;
    if (chk_valid) begin
      exp_sum  = sum_q[LATENCY-1];
      mismatch = (res != sum_q[LATENCY-1]);
    end else begin
      exp_sum  = {WIDTH{1'b0}};
      mismatch = 1'b0;
    end
  end

  // Next-state of counters and snapshot; clear discards the compare of its cycle
  always_comb begin
    pass_d      = pass_q;
    err_d       = err_q;
    fail_d      = fail_q;
    first_a_d   = first_a_q;
    first_b_d   = first_b_q;
    first_got_d = first_got_q;
    if (clear) begin
      pass_d      = {CNT_W{1'b0}};
      err_d       = {CNT_W{1'b0}};
      fail_d      = 1'b0;
      first_a_d   = {WIDTH{1'b0}};
      first_b_d   = {WIDTH{1'b0}};
      first_got_d = {WIDTH{1'b0}};
    end else if (chk_valid) begin
      if (mismatch) begin
        if (err_q != CNT_MAX) begin
          err_d = err_q + CNT_ONE;
        end else begin
          err_d = err_q;
        end
        // Only the first failure since rst/clear is captured
        if (!fail_q) begin
          fail_d      = 1'b1;
          first_a_d   = a_q[LATENCY-1];
          first_b_d   = b_q[LATENCY-1];
          first_got_d = res;
        end else begin
          fail_d = fail_q;
        end
      end else begin
        if (pass_q != CNT_MAX) begin
          pass_d = pass_q + CNT_ONE;
        end else begin
          pass_d = pass_q;
        end
      end
    end else begin
      pass_d = pass_q;
      err_d  = err_q;
    end
  end

  // Counter and snapshot registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q      <= {CNT_W{1'b0}};
      err_q       <= {CNT_W{1'b0}};
      fail_q      <= 1'b0;
      first_a_q   <= {WIDTH{1'b0}};
      first_b_q   <= {WIDTH{1'b0}};
      first_got_q <= {WIDTH{1'b0}};
    end else begin
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_q      <= fail_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
      first_got_q <= first_got_d;
    end
  end

  assign pass_cnt  = pass_q;
  assign err_cnt   = err_q;
  assign fail      = fail_q;
  assign first_a   = first_a_q;
  assign first_b   = first_b_q;
  assign first_got = first_got_q;

endmodule

// File: tb/tb_add_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_add_resp_checker
//
// Two checker instances share one clock: dut_a (LATENCY=1, CNT_W=4) and
// dut_b (LATENCY=3, CNT_W=16). A small registered adder model in the bench
// produces res for each instance, and a per-test override can force a wrong
// value for one cycle. Every accepted operand pair pushes its expected sum,
// stamped with the cycle where its compare is due, into a queue. A negedge
// monitor pops that queue whenever chk_valid is seen and checks the timing,
// exp_sum and mismatch. Each test task checks the counters and the snapshot
// inline.
// -----------------------------------------------------------------------------
module tb_add_resp_checker;

  typedef struct {
    int          at_step;
    logic [31:0] sum;
  } sb_t;

  logic clk;
  int   n_cmp;
  int   n_err;
  int   stp;
  logic mon_en;

  // dut_a signals
  logic        rst_a, clr_a, v_a, ovr_a;
  logic [31:0] a_a, b_a, ovr_val_a, res_a, add_a_q;
  logic        chkv_a, mm_a, fail_a;
  logic [31:0] exp_a, fa_a, fb_a, fg_a;
  logic [3:0]  pass_a, err_a;

  // dut_b signals
  logic        rst_b, clr_b, v_b, ovr_b;
  logic [31:0] a_b, b_b, ovr_val_b, res_b, add_b0, add_b1, add_b2;
  logic        chkv_b, mm_b, fail_b;
  logic [31:0] exp_b, fa_b, fb_b, fg_b;
  logic [15:0] pass_b, err_b;

  sb_t sb_a[$];
  sb_t sb_b[$];
  sb_t ent_a, ent_b;

  add_resp_checker #(.WIDTH(32), .LATENCY(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst_a), .clear(clr_a), .op_valid(v_a), .op_a(a_a), .op_b(b_a),
    .res(res_a), .chk_valid(chkv_a), .mismatch(mm_a), .exp_sum(exp_a),
    .pass_cnt(pass_a), .err_cnt(err_a), .fail(fail_a),
    .first_a(fa_a), .first_b(fb_a), .first_got(fg_a)
  );

  add_resp_checker #(.WIDTH(32), .LATENCY(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .clear(clr_b), .op_valid(v_b), .op_a(a_b), .op_b(b_b),
    .res(res_b), .chk_valid(chkv_b), .mismatch(mm_b), .exp_sum(exp_b),
    .pass_cnt(pass_b), .err_cnt(err_b), .fail(fail_b),
    .first_a(fa_b), .first_b(fb_b), .first_got(fg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adders under observation: 1-cycle for dut_a, 3-cycle for dut_b
  always @(posedge clk) begin
    add_a_q <= a_a + b_a;
    add_b0  <= a_b + b_b;
    add_b1  <= add_b0;
    add_b2  <= add_b1;
  end

  assign res_a = ovr_a ? ovr_val_a : add_a_q;
  assign res_b = ovr_b ? ovr_val_b : add_b2;

  // Scoreboard monitor for dut_a
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (chkv_a === 1'b1) begin
        if (sb_a.size() == 0) begin
          n_err++;
          $display("FAIL mon_a_spurious: step %0d chk_valid got 1 want 0", stp);
        end else begin
          ent_a = sb_a.pop_front();
          if (ent_a.at_step != stp || exp_a !== ent_a.sum || mm_a !== (res_a !== ent_a.sum)) begin
            n_err++;
            $display("FAIL mon_a_compare: got step=%0d exp_sum=%h mismatch=%b want step=%0d exp_sum=%h mismatch=%b",
                     stp, exp_a, mm_a, ent_a.at_step, ent_a.sum, (res_a !== ent_a.sum));
          end
        end
      end else if (chkv_a !== 1'b0 || exp_a !== 32'd0 || mm_a !== 1'b0) begin
        n_err++;
        $display("FAIL mon_a_idle: step %0d got chk_valid=%b exp_sum=%h mismatch=%b want 0/0/0", stp, chkv_a, exp_a, mm_a);
      end else if (sb_a.size() != 0 && sb_a[0].at_step <= stp) begin
        n_err++;
        $display("FAIL mon_a_missing: step %0d chk_valid got 0 want 1 (exp_sum %h)", stp, sb_a[0].sum);
        void'(sb_a.pop_front());
      end
    end
  end

  // Scoreboard monitor for dut_b
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (chkv_b === 1'b1) begin
        if (sb_b.size() == 0) begin
          n_err++;
          $display("FAIL mon_b_spurious: step %0d chk_valid got 1 want 0", stp);
        end else begin
          ent_b = sb_b.pop_front();
          if (ent_b.at_step != stp || exp_b !== ent_b.sum || mm_b !== (res_b !== ent_b.sum)) begin
            n_err++;
            $display("FAIL mon_b_compare: got step=%0d exp_sum=%h mismatch=%b want step=%0d exp_sum=%h mismatch=%b",
                     stp, exp_b, mm_b, ent_b.at_step, ent_b.sum, (res_b !== ent_b.sum));
          end
        end
      end else if (chkv_b !== 1'b0 || exp_b !== 32'd0 || mm_b !== 1'b0) begin
        n_err++;
        $display("FAIL mon_b_idle: step %0d got chk_valid=%b exp_sum=%h mismatch=%b want 0/0/0", stp, chkv_b, exp_b, mm_b);
      end else if (sb_b.size() != 0 && sb_b[0].at_step <= stp) begin
        n_err++;
        $display("FAIL mon_b_missing: step %0d chk_valid got 0 want 1 (exp_sum %h)", stp, sb_b[0].sum);
        void'(sb_b.pop_front());
      end
    end
  end

  // One clock: monitors sample at negedge; accepted operands enter the scoreboard at posedge
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    if (rst_a || clr_a) sb_a.delete();
    else if (v_a) sb_a.push_back('{at_step: stp + 1, sum: a_a + b_a});
    if (rst_b || clr_b) sb_b.delete();
    else if (v_b) sb_b.push_back('{at_step: stp + 3, sum: a_b + b_b});
    #1;
    stp++;
    ovr_a = 1'b0;
    ovr_b = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;
    n_cmp++;
    if ({chkv_a, mm_a, exp_a, pass_a, err_a, fail_a, fa_a, fb_a, fg_a} !== '0) begin
      n_err++;
      $display("FAIL reset_a: got chk=%b mm=%b exp=%h pass=%0d err=%0d fail=%b first=%h/%h/%h want all 0",
               chkv_a, mm_a, exp_a, pass_a, err_a, fail_a, fa_a, fb_a, fg_a);
    end
    n_cmp++;
    if ({chkv_b, mm_b, exp_b, pass_b, err_b, fail_b, fa_b, fb_b, fg_b} !== '0) begin
      n_err++;
      $display("FAIL reset_b: got chk=%b mm=%b exp=%h pass=%0d err=%0d fail=%b first=%h/%h/%h want all 0",
               chkv_b, mm_b, exp_b, pass_b, err_b, fail_b, fa_b, fb_b, fg_b);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    v_a = 1'b1; a_a = 32'd15; b_a = 32'd20; step();
    a_a = 32'd34; b_a = 32'd45; step();
    v_a = 1'b0; step(); step();
    n_cmp++;
    if (pass_a !== 4'd2 || err_a !== 4'd0 || fail_a !== 1'b0) begin
      n_err++;
      $display("FAIL basic_counts: got pass=%0d err=%0d fail=%b want 2/0/0", pass_a, err_a, fail_a);
    end
  endtask

  task automatic test_wrap();
    v_a = 1'b1; a_a = 32'hFFFF_FFFF; b_a = 32'd2; step();
    v_a = 1'b0; step();
    n_cmp++;
    if (pass_a !== 4'd3 || err_a !== 4'd0 || fail_a !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_counts: got pass=%0d err=%0d fail=%b want 3/0/0", pass_a, err_a, fail_a);
    end
  endtask

  task automatic test_fault();
    v_a = 1'b1; a_a = 32'd7; b_a = 32'd8; step();
    v_a = 1'b0; ovr_a = 1'b1; ovr_val_a = 32'd14; step();
    step();
    n_cmp++;
    if (err_a !== 4'd1 || fail_a !== 1'b1 || pass_a !== 4'd3) begin
      n_err++;
      $display("FAIL fault_counts: got err=%0d fail=%b pass=%0d want 1/1/3", err_a, fail_a, pass_a);
    end
    n_cmp++;
    if (fa_a !== 32'd7 || fb_a !== 32'd8 || fg_a !== 32'd14) begin
      n_err++;
      $display("FAIL fault_snapshot: got a=%0d b=%0d got=%0d want 7/8/14", fa_a, fb_a, fg_a);
    end
    v_a = 1'b1; a_a = 32'd1; b_a = 32'd1; step();
    v_a = 1'b0; ovr_a = 1'b1; ovr_val_a = 32'd3; step();
    step();
    n_cmp++;
    if (err_a !== 4'd2 || fail_a !== 1'b1 || fa_a !== 32'd7 || fb_a !== 32'd8 || fg_a !== 32'd14) begin
      n_err++;
      $display("FAIL fault_second: got err=%0d fail=%b snap=%0d/%0d/%0d want 2/1/7/8/14", err_a, fail_a, fa_a, fb_a, fg_a);
    end
  endtask

  task automatic test_saturate();
    clr_a = 1'b1; step();
    n_cmp++;
    if ({pass_a, err_a, fail_a, fa_a, fb_a, fg_a} !== '0) begin
      n_err++;
      $display("FAIL clear_a: got pass=%0d err=%0d fail=%b snap=%h/%h/%h want all 0", pass_a, err_a, fail_a, fa_a, fb_a, fg_a);
    end
    v_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_a = $urandom; b_a = $urandom;
      step();
      if (i == 9) begin
        n_cmp++;
        if (pass_a !== 4'd9) begin
          n_err++;
          $display("FAIL sat_mid: got pass=%0d want 9", pass_a);
        end
      end
    end
    v_a = 1'b0; step(); step();
    n_cmp++;
    if (pass_a !== 4'd15 || err_a !== 4'd0) begin
      n_err++;
      $display("FAIL sat_final: got pass=%0d err=%0d want 15/0", pass_a, err_a);
    end
  endtask

  task automatic test_bubbles();
    v_b = 1'b1; a_b = 32'd100; b_b = 32'd200; step();
    v_b = 1'b0; a_b = 32'd5;   b_b = 32'd6;   step();
    v_b = 1'b1; a_b = 32'd300; b_b = 32'd400; step();
    a_b = 32'd500; b_b = 32'd600; step();
    v_b = 1'b0; ovr_b = 1'b1; ovr_val_b = 32'hDEAD; step();
    step(); step(); step();
    n_cmp++;
    if (pass_b !== 16'd3 || err_b !== 16'd0 || fail_b !== 1'b0) begin
      n_err++;
      $display("FAIL bubble_counts: got pass=%0d err=%0d fail=%b want 3/0/0", pass_b, err_b, fail_b);
    end
  endtask

  task automatic test_rst_clear();
    v_b = 1'b1; a_b = 32'd10; b_b = 32'd20; step();
    a_b = 32'd30; b_b = 32'd40; step();
    v_b = 1'b0; rst_b = 1'b1; step();
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (pass_b !== 16'd0 || err_b !== 16'd0 || fail_b !== 1'b0 || chkv_b !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flight: got pass=%0d err=%0d fail=%b chk=%b want 0/0/0/0", pass_b, err_b, fail_b, chkv_b);
    end
    v_b = 1'b1; a_b = 32'd1; b_b = 32'd1; step();
    v_b = 1'b0; step(); step();
    // bad compare lands in the clear cycle; operands offered alongside clear are dropped
    v_b = 1'b1; a_b = 32'd50; b_b = 32'd50; clr_b = 1'b1; ovr_b = 1'b1; ovr_val_b = 32'd99; step();
    v_b = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (err_b !== 16'd0 || fail_b !== 1'b0 || pass_b !== 16'd0 || fg_b !== 32'd0) begin
      n_err++;
      $display("FAIL clear_compare: got err=%0d fail=%b pass=%0d first_got=%0d want 0/0/0/0", err_b, fail_b, pass_b, fg_b);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; stp = 0; mon_en = 1'b0;
    rst_a = 1'b1; clr_a = 1'b0; v_a = 1'b0; ovr_a = 1'b0; a_a = 32'd0; b_a = 32'd0; ovr_val_a = 32'd0;
    rst_b = 1'b1; clr_b = 1'b0; v_b = 1'b0; ovr_b = 1'b0; a_b = 32'd0; b_b = 32'd0; ovr_val_b = 32'd0;
    test_reset();
    test_basic();
    test_wrap();
    test_fault();
    test_saturate();
    test_bubbles();
    test_rst_clear();
    n_cmp++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d pending compares want 0/0", sb_a.size(), sb_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
